// File: rtl/motor3_sixstep_ctrl.sv
// motor3_sixstep_ctrl: six-step trapezoidal commutation controller for one
// three-phase motor driving three IRS2007S-style half-bridge gate inputs.
//
// Ports:
//   clkI            clock (1 MHz nominal)
//   nRstI           asynchronous active-low reset
//   m3startI        run enable (level)
//   m3forceStopI    brake request (level, highest priority)
//   m3invRotateI    0 forward, 1 reverse (level)
//   m3speedINCi/DECi, m3powerINCi/DECi   adjust requests, acted on at rising edge
//   aHpO/bHpO/cHpO  high-side gates, active-high
//   aLpO/bLpO/cLpO  low-side gates, active-low (1 = off)
//   m3runO          FSM in RUN or BLANK
//   m3stepO         current commutation step 0..5
//   m3speedO        speed register (NCO increment)
//   m3powerO        power register (PWM compare level)
module motor3_sixstep_ctrl #(
    parameter int PWM_W    = 8,
    parameter int DEAD_CYC = 4,
    parameter int ACC_W    = 20,
    parameter int SPD_W    = 10,
    parameter int SPD_MIN  = 1,
    parameter int SPD_MAX  = 1000,
    parameter int SPD_STEP = 1,
    parameter int PWR_STEP = 8
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             m3startI,
    input  logic             m3forceStopI,
    input  logic             m3invRotateI,
    input  logic             m3speedINCi,
    input  logic             m3speedDECi,
    input  logic             m3powerINCi,
    input  logic             m3powerDECi,
    output logic             aHpO,
    output logic             bHpO,
    output logic             cHpO,
    output logic             aLpO,
    output logic             bLpO,
    output logic             cLpO,
    output logic             m3runO,
    output logic [2:0]       m3stepO,
    output logic [SPD_W-1:0] m3speedO,
    output logic [PWM_W-1:0] m3powerO
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] BRAKE = 2'd3;

    localparam int CNT_W = $clog2(DEAD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYC - 1);

    localparam logic [SPD_W-1:0] SPD_LO     = SPD_W'(SPD_MIN);
    localparam logic [SPD_W-1:0] SPD_HI     = SPD_W'(SPD_MAX);
    localparam logic [SPD_W-1:0] SPD_INC    = SPD_W'(SPD_STEP);
    localparam logic [SPD_W-1:0] SPD_UP_LIM = SPD_W'(SPD_MAX - SPD_STEP);
    localparam logic [SPD_W-1:0] SPD_DN_LIM = SPD_W'(SPD_MIN + SPD_STEP);
    localparam logic [PWM_W-1:0] PWR_INC    = PWM_W'(PWR_STEP);
    localparam logic [PWM_W-1:0] PWR_UP_LIM = {PWM_W{1'b1}} - PWR_INC;

    logic             startR, stopR, invR;
    logic [3:0]       adjR, adjP, adjEdge;
    logic             spdUp, spdDn, pwrUp, pwrDn;
    logic [1:0]       state, target;
    logic [CNT_W-1:0] blankCnt;
    logic [2:0]       step, nextStep, hiSel, loSel, hiN, loN, hOut, lOut;
    logic             dir;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   accSum;
    logic [PWM_W-1:0] pwmCnt, power;
    logic [SPD_W-1:0] speed;

    // adj vectors are {powerDEC, powerINC, speedDEC, speedINC}
    assign adjEdge = adjR & ~adjP;
    assign spdUp   = adjEdge[0] & ~adjEdge[1];
    assign spdDn   = adjEdge[1] & ~adjEdge[0];
    assign pwrUp   = adjEdge[2] & ~adjEdge[3];
    assign pwrDn   = adjEdge[3] & ~adjEdge[2];

    // Carry out of the accumulator is the commutation tick
    assign accSum   = {1'b0, acc} + (ACC_W + 1)'(speed);
    assign nextStep = dir ? (step == 3'd0 ? 3'd5 : step - 3'd1)
                          : (step == 3'd5 ? 3'd0 : step + 3'd1);

    // One-hot phase selects, bit0 = A, bit1 = B, bit2 = C
    assign hiSel = step < 3'd2 ? 3'b001 : step < 3'd4 ? 3'b010 : 3'b100;
    assign loSel = (step == 3'd0 || step == 3'd5) ? 3'b010 :
                   (step == 3'd1 || step == 3'd2) ? 3'b100 : 3'b001;

    assign hiN = state == RUN ? (hiSel & {3{pwmCnt < power}}) : 3'b000;
    assign loN = state == RUN ? ~loSel : state == BRAKE ? 3'b000 : 3'b111;

    assign {cHpO, bHpO, aHpO} = hOut;
    assign {cLpO, bLpO, aLpO} = lOut;
    assign m3runO   = state == RUN || state == BLANK;
    assign m3stepO  = step;
    assign m3speedO = speed;
    assign m3powerO = power;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            startR <= 1'b0;
            stopR  <= 1'b0;
            invR   <= 1'b0;
            adjR   <= '0;
            adjP   <= '0;
        end else begin
            startR <= m3startI;
            stopR  <= m3forceStopI;
            invR   <= m3invRotateI;
            adjR   <= {m3powerDECi, m3powerINCi, m3speedDECi, m3speedINCi};
            adjP   <= adjR;
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            speed  <= SPD_LO;
            power  <= '0;
            pwmCnt <= '0;
        end else begin
            pwmCnt <= pwmCnt + 1'b1;
            if (spdUp)
                speed <= speed >= SPD_UP_LIM ? SPD_HI : speed + SPD_INC;
            else if (spdDn)
                speed <= speed <= SPD_DN_LIM ? SPD_LO : speed - SPD_INC;
            if (pwrUp)
                power <= power >= PWR_UP_LIM ? {PWM_W{1'b1}} : power + PWR_INC;
            else if (pwrDn)
                power <= power <= PWR_INC ? '0 : power - PWR_INC;
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state    <= IDLE;
            target   <= RUN;
            blankCnt <= '0;
            step     <= 3'd0;
            dir      <= 1'b0;
            acc      <= '0;
        end else if (stopR && state != BRAKE && !(state == BLANK && target == BRAKE)) begin
            state    <= BLANK;
            target   <= BRAKE;
            blankCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    step <= 3'd0;
                    acc  <= '0;
                    dir  <= invR;
                    if (startR) begin
                        state    <= BLANK;
                        target   <= RUN;
                        blankCnt <= '0;
                    end
                end
                BLANK: begin
                    if (blankCnt == CNT_LAST)
                        state <= target;
                    else
                        blankCnt <= blankCnt + 1'b1;
                end
                RUN: begin
                    acc <= startR ? accSum[ACC_W-1:0] : '0;
                    if (!startR)
                        state <= IDLE;
                    else if (invR != dir) begin
                        // A tick coinciding with a reversal is dropped like any blanked tick
                        dir      <= invR;
                        state    <= BLANK;
                        target   <= RUN;
                        blankCnt <= '0;
                    end else if (accSum[ACC_W]) begin
                        step     <= nextStep;
                        state    <= BLANK;
                        target   <= RUN;
                        blankCnt <= '0;
                    end
                end
                BRAKE: begin
                    acc <= '0;
                    if (!stopR)
                        state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            hOut <= 3'b000;
            lOut <= 3'b111;
        end else begin
            hOut <= hiN;
            lOut <= loN;
        end
    end
endmodule

// File: tb/tb_motor3_sixstep_ctrl.sv
// tb_motor3_sixstep_ctrl: randomized self-checking bench for motor3_sixstep_ctrl
module tb_motor3_sixstep_ctrl;
    localparam int D    = 4;
    localparam int FULL = 1 << 20;

    logic clkI = 1'b0, nRstI = 1'b0;
    logic startIn = 1'b0, stopIn = 1'b0, invIn = 1'b0;
    logic spdInc = 1'b0, spdDec = 1'b0, pwrInc = 1'b0, pwrDec = 1'b0;
    logic aHpO, bHpO, cHpO, aLpO, bLpO, cLpO, m3runO;
    logic [2:0] m3stepO;
    logic [9:0] m3speedO;
    logic [7:0] m3powerO;
    logic [2:0] hv, lv;

    int checks = 0, errors = 0;
    int mSpd = 1, mPwr = 0, mAcc = 0;
    int hiTab [6] = '{0, 0, 1, 1, 2, 2};
    int loTab [6] = '{1, 2, 2, 0, 0, 1};

    assign hv = {cHpO, bHpO, aHpO};
    assign lv = {cLpO, bLpO, aLpO};

    always #5 clkI = ~clkI;

    motor3_sixstep_ctrl dut (
        .clkI(clkI), .nRstI(nRstI), .m3startI(startIn), .m3forceStopI(stopIn),
        .m3invRotateI(invIn), .m3speedINCi(spdInc), .m3speedDECi(spdDec),
        .m3powerINCi(pwrInc), .m3powerDECi(pwrDec),
        .aHpO(aHpO), .bHpO(bHpO), .cHpO(cHpO), .aLpO(aLpO), .bLpO(bLpO), .cLpO(cLpO),
        .m3runO(m3runO), .m3stepO(m3stepO), .m3speedO(m3speedO), .m3powerO(m3powerO)
    );

    // Run-cycles until the next NCO carry, from integer accumulation
    function automatic int nextLen();
        int k;
        k = 0;
        while (mAcc < FULL) begin
            mAcc += mSpd;
            k++;
        end
        mAcc -= FULL;
        return k;
    endfunction

    function automatic int decodeStep(logic [2:0] hs, logic [2:0] ls);
        for (int s = 0; s < 6; s++)
            if (hs == 3'(1 << hiTab[s]) && ls == 3'(1 << loTab[s])) return s;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clkI);
    endtask

    // op: 0 spd+, 1 spd-, 2 pwr+, 3 pwr-, 4 spd both, 5 pwr both
    task automatic pulse(input int op, input int hold, input int gap);
        spdInc = op == 0 || op == 4;
        spdDec = op == 1 || op == 4;
        pwrInc = op == 2 || op == 5;
        pwrDec = op == 3 || op == 5;
        tick(hold);
        {spdInc, spdDec, pwrInc, pwrDec} = 4'b0000;
        tick(gap);
        if (op == 0) mSpd = mSpd + 1 > 1000 ? 1000 : mSpd + 1;
        if (op == 1) mSpd = mSpd - 1 < 1 ? 1 : mSpd - 1;
        if (op == 2) mPwr = mPwr + 8 > 255 ? 255 : mPwr + 8;
        if (op == 3) mPwr = mPwr - 8 < 0 ? 0 : mPwr - 8;
    endtask

    task automatic measureDrive(input int maxLen, output int len, output int st,
                                output int hcw, output int clash);
        logic [2:0] hs, ls;
        hs = 3'b000;
        ls = 3'b000;
        len = 0;
        hcw = 0;
        clash = 0;
        while (lv != 3'b111 && len < maxLen) begin
            len++;
            hs |= hv;
            ls |= ~lv;
            if (len <= 256 && hv != 3'b000) hcw++;
            if ((hv & ~lv) != 3'b000) clash++;
            @(negedge clkI);
        end
        st = decodeStep(hs, ls);
    endtask

    task automatic measureGap(input int maxLen, output int len);
        len = 0;
        while (hv == 3'b000 && lv == 3'b111 && len < maxLen) begin
            len++;
            @(negedge clkI);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (hv !== 3'b000 || lv !== 3'b111) begin
            errors++;
            $display("FAIL rst_held gates h=%b l=%b want h=000 l=111", hv, lv);
        end
        nRstI = 1'b1;
        tick(3);
        checks++;
        if (m3runO !== 1'b0 || m3stepO !== 3'd0) begin
            errors++;
            $display("FAIL rst_state run=%b step=%0d want run=0 step=0", m3runO, m3stepO);
        end
        checks++;
        if (m3speedO !== 10'd1 || m3powerO !== 8'd0) begin
            errors++;
            $display("FAIL rst_regs speed=%0d power=%0d want 1 0", m3speedO, m3powerO);
        end
        checks++;
        if (hv !== 3'b000 || lv !== 3'b111) begin
            errors++;
            $display("FAIL rst_gates h=%b l=%b want h=000 l=111", hv, lv);
        end
    endtask

    task automatic test_adjust();
        for (int i = 0; i < 60; i++) begin
            pulse($urandom_range(0, 5), $urandom_range(1, 3), $urandom_range(1, 3));
            checks++;
            if (int'(m3speedO) !== mSpd || int'(m3powerO) !== mPwr) begin
                errors++;
                $display("FAIL adjust op%0d speed=%0d power=%0d want %0d %0d",
                         i, m3speedO, m3powerO, mSpd, mPwr);
            end
        end
    endtask

    task automatic test_speed_limits();
        while (mSpd > 1) pulse(1, 1, 1);
        repeat (3) pulse(1, 1, 1);
        checks++;
        if (m3speedO !== 10'd1) begin
            errors++;
            $display("FAIL spd_min_dec speed=%0d want 1", m3speedO);
        end
        pulse(4, 10, 2);
        checks++;
        if (m3speedO !== 10'd1) begin
            errors++;
            $display("FAIL spd_both speed=%0d want 1", m3speedO);
        end
        repeat (1000) pulse(0, 1, 1);
        checks++;
        if (m3speedO !== 10'd1000) begin
            errors++;
            $display("FAIL spd_max speed=%0d want 1000", m3speedO);
        end
        pulse(0, 1, 1);
        checks++;
        if (m3speedO !== 10'd1000) begin
            errors++;
            $display("FAIL spd_max_sat speed=%0d want 1000", m3speedO);
        end
    endtask

    task automatic test_forward();
        int n, len, st, hcw, cl, gap;
        while (mPwr > 0) pulse(3, 1, 1);
        repeat (16) pulse(2, 1, 1);
        checks++;
        if (m3powerO !== 8'd128) begin
            errors++;
            $display("FAIL fwd_power power=%0d want 128", m3powerO);
        end
        mAcc = 0;
        startIn = 1'b1;
        @(negedge clkI);
        n = 1;
        while (lv == 3'b111 && n < 50) begin
            @(negedge clkI);
            n++;
        end
        checks++;
        if (n !== D + 3) begin
            errors++;
            $display("FAIL fwd_start_latency got %0d want %0d", n, D + 3);
        end
        checks++;
        if (m3runO !== 1'b1) begin
            errors++;
            $display("FAIL fwd_run run=%b want 1", m3runO);
        end
        for (int i = 0; i < 7; i++) begin
            measureDrive(5000, len, st, hcw, cl);
            n = nextLen();
            checks++;
            if (st !== i % 6 || len !== n) begin
                errors++;
                $display("FAIL fwd_seg%0d step=%0d len=%0d want step=%0d len=%0d", i, st, len, i % 6, n);
            end
            checks++;
            if (hcw !== 128 || cl !== 0) begin
                errors++;
                $display("FAIL fwd_pwm%0d hi=%0d clash=%0d want 128 0", i, hcw, cl);
            end
            measureGap(100, gap);
            checks++;
            if (gap !== D) begin
                errors++;
                $display("FAIL fwd_gap%0d got %0d want %0d", i, gap, D);
            end
        end
        startIn = 1'b0;
        tick(5);
        checks++;
        if (hv !== 3'b000 || lv !== 3'b111 || m3runO !== 1'b0 || m3stepO !== 3'd0) begin
            errors++;
            $display("FAIL fwd_coast h=%b l=%b run=%b step=%0d want 000 111 0 0", hv, lv, m3runO, m3stepO);
        end
    endtask

    task automatic test_reverse();
        int n, len, lenA, lenB, st, hcw, cl, gap;
        int expSt [3] = '{1, 0, 5};
        mAcc = 0;
        startIn = 1'b1;
        n = 0;
        while (lv == 3'b111 && n < 50) begin
            @(negedge clkI);
            n++;
        end
        for (int i = 0; i < 2; i++) begin
            measureDrive(5000, len, st, hcw, cl);
            n = nextLen();
            checks++;
            if (st !== i || len !== n) begin
                errors++;
                $display("FAIL rev_pre%0d step=%0d len=%0d want %0d %0d", i, st, len, i, n);
            end
            measureGap(100, gap);
        end
        measureDrive(100, lenA, st, hcw, cl);
        checks++;
        if (st !== 2 || lenA !== 100) begin
            errors++;
            $display("FAIL rev_at2 step=%0d len=%0d want 2 100", st, lenA);
        end
        invIn = 1'b1;
        measureDrive(5000, lenB, st, hcw, cl);
        measureGap(100, gap);
        checks++;
        if (lenB !== 3 || gap !== D) begin
            errors++;
            $display("FAIL rev_blank tail=%0d gap=%0d want 3 %0d", lenB, gap, D);
        end
        measureDrive(5000, len, st, hcw, cl);
        n = nextLen();
        checks++;
        if (st !== 2 || lenA + lenB + len !== n) begin
            errors++;
            $display("FAIL rev_resume step=%0d total=%0d want 2 %0d", st, lenA + lenB + len, n);
        end
        for (int i = 0; i < 3; i++) begin
            measureGap(100, gap);
            checks++;
            if (gap !== D) begin
                errors++;
                $display("FAIL rev_gap%0d got %0d want %0d", i, gap, D);
            end
            measureDrive(5000, len, st, hcw, cl);
            n = nextLen();
            checks++;
            if (st !== expSt[i] || len !== n || cl !== 0) begin
                errors++;
                $display("FAIL rev_seg%0d step=%0d len=%0d clash=%0d want %0d %0d 0",
                         i, st, len, cl, expSt[i], n);
            end
        end
        startIn = 1'b0;
        tick(5);
        invIn = 1'b0;
        tick(2);
    endtask

    task automatic test_brake();
        int n, len, st, hcw, cl, gap, bad;
        startIn = 1'b1;
        n = 0;
        while (lv == 3'b111 && n < 50) begin
            @(negedge clkI);
            n++;
        end
        measureDrive(100, len, st, hcw, cl);
        stopIn = 1'b1;
        measureDrive(10, len, st, hcw, cl);
        measureGap(50, gap);
        checks++;
        if (len !== 3 || gap !== D) begin
            errors++;
            $display("FAIL brk_entry tail=%0d gap=%0d want 3 %0d", len, gap, D);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (hv !== 3'b000 || lv !== 3'b000 || m3runO !== 1'b0) bad++;
            @(negedge clkI);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL brk_pattern bad_cycles=%0d want 0", bad);
        end
        startIn = 1'b0;
        tick(3);
        stopIn = 1'b0;
        tick(5);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (hv !== 3'b000 || lv !== 3'b111 || m3runO !== 1'b0) bad++;
            @(negedge clkI);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL brk_release bad_cycles=%0d want 0", bad);
        end
        mAcc = 0;
        startIn = 1'b1;
        @(negedge clkI);
        n = 1;
        while (lv == 3'b111 && n < 50) begin
            @(negedge clkI);
            n++;
        end
        checks++;
        if (n !== D + 3) begin
            errors++;
            $display("FAIL brk_restart latency=%0d want %0d", n, D + 3);
        end
    endtask

    task automatic test_power();
        int len, st, hcw, cl, cnt;
        while (mPwr > 0) pulse(3, 1, 1);
        pulse(3, 1, 1);
        checks++;
        if (m3powerO !== 8'd0) begin
            errors++;
            $display("FAIL pwr_zero power=%0d want 0", m3powerO);
        end
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (hv != 3'b000) cnt++;
            @(negedge clkI);
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL pwr_zero_pulses got %0d want 0", cnt);
        end
        for (int it = 0; it < 4; it++) begin
            if (it < 3) repeat ($urandom_range(4, 30)) pulse($urandom_range(2, 3), 1, 1);
            else repeat (33) pulse(2, 1, 1);
            checks++;
            if (int'(m3powerO) !== mPwr) begin
                errors++;
                $display("FAIL pwr_level%0d power=%0d want %0d", it, m3powerO, mPwr);
            end
            measureDrive(5000, len, st, hcw, cl);
            measureGap(100, len);
            measureDrive(256, len, st, hcw, cl);
            checks++;
            if (len !== 256 || hcw !== mPwr || cl !== 0) begin
                errors++;
                $display("FAIL pwr_duty%0d len=%0d hi=%0d clash=%0d want 256 %0d 0", it, len, hcw, cl, mPwr);
            end
            if (it == 3) begin
                checks++;
                if (hcw !== 255) begin
                    errors++;
                    $display("FAIL pwr_full hi=%0d want 255", hcw);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (hv == 3'b000 && n < 2000) begin
            @(negedge clkI);
            n++;
        end
        checks++;
        if (hv === 3'b000) begin
            errors++;
            $display("FAIL arst_pulse h=%b want nonzero", hv);
        end
        #2 nRstI = 1'b0;
        #1;
        checks++;
        if (hv !== 3'b000 || lv !== 3'b111) begin
            errors++;
            $display("FAIL arst_immediate h=%b l=%b want 000 111", hv, lv);
        end
        startIn = 1'b0;
        @(negedge clkI);
        nRstI = 1'b1;
        mSpd = 1;
        mPwr = 0;
        tick(3);
        checks++;
        if (m3runO !== 1'b0 || m3stepO !== 3'd0 || m3speedO !== 10'd1 || m3powerO !== 8'd0) begin
            errors++;
            $display("FAIL arst_after run=%b step=%0d speed=%0d power=%0d want 0 0 1 0",
                     m3runO, m3stepO, m3speedO, m3powerO);
        end
        checks++;
        if (hv !== 3'b000 || lv !== 3'b111) begin
            errors++;
            $display("FAIL arst_gates h=%b l=%b want 000 111", hv, lv);
        end
    endtask

    initial begin
        test_reset();
        test_adjust();
        test_speed_limits();
        test_forward();
        test_reverse();
        test_brake();
        test_power();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
